// File: rtl/sync_fifo_pkg.sv
// Shared sizing and level helpers for the single-clock prefetch FIFO.
// Imported by the FIFO top and its prefetch queue.
package sync_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int fifo_cap(input int addr_w, input int pf_depth);
    return (1 << addr_w) + pf_depth;
  endfunction

  function automatic int fifo_lvl_w(input int addr_w, input int pf_depth);
    return clog2(fifo_cap(addr_w, pf_depth) + 1);
  endfunction

  function automatic logic lvl_ge(input int lvl, input int thr);
    return lvl >= thr;
  endfunction

  function automatic logic lvl_le(input int lvl, input int thr);
    return lvl <= thr;
  endfunction

endpackage

// File: rtl/sync_prefetch_queue.sv
// Small first-word-fall-through register queue behind the FIFO RAM.
// Slot 0 is always the head; a pop shifts the remaining slots down.
module sync_prefetch_queue
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     q_cnt
);

  logic [DATA_W-1:0] slot   [DEPTH];
  logic [DATA_W-1:0] slot_n [DEPTH];
  logic              push;
  logic              pop;

  assign out_valid = (q_cnt != '0);
  assign out_data  = slot[0];
  assign in_ready  = (int'(q_cnt) < DEPTH) | out_ready;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & in_ready;

  // Next slot contents: shift on pop, then land the new word behind the tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_n[i] = slot[i];
    if (pop)
      for (int i = 0; i < DEPTH - 1; i++) slot_n[i] = slot[i+1];
    for (int i = 0; i < DEPTH; i++)
      if (push && (i == int'(q_cnt) - int'(pop))) slot_n[i] = in_data;
  end

  // Slot storage and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
      q_cnt <= '0;
    end else begin
      slot  <= slot_n;
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/sync_prefetch_fifo.sv
// Single-clock FWFT FIFO: synchronous-read RAM feeding a prefetch queue.
// Level, almost flags, flush and sticky overflow live here.
module sync_prefetch_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int PF_DEPTH = 2,
  parameter int AF_LEVEL = (1 << ADDR_W) - 4,
  parameter int AE_LEVEL = 2,
  localparam int LVL_W   = fifo_lvl_w(ADDR_W, PF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [LVL_W-1:0]  level,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  input  logic              err_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int QW    = clog2(PF_DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              inflight;
  logic [QW-1:0]     q_cnt;
  logic              push;
  logic              pop;
  logic              ram_rd;
  logic              q_in_ready_unused;
  logic [LVL_W-1:0]  level_next;

  // Full only when the RAM itself is full; independent of rd_ready
  assign wr_ready = ~ram_cnt[ADDR_W];
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;

  // Issue a RAM read only if the queue can absorb it next cycle
  assign ram_rd = (ram_cnt != '0) &&
                  (int'(q_cnt) + int'(inflight) - int'(pop) < PF_DEPTH);

  assign level_next = level + LVL_W'(push) - LVL_W'(pop);

  // RAM write port and registered read port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
    if (ram_rd) ram_q <= mem[rd_ptr];
  end

  // Pointers, RAM occupancy and read-in-flight flag
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (ram_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      ram_cnt  <= ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(ram_rd);
      inflight <= ram_rd;
    end
  end

  // Total occupancy and registered almost flags
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      level        <= level_next;
      almost_full  <= lvl_ge(int'(level_next), AF_LEVEL);
      almost_empty <= lvl_le(int'(level_next), AE_LEVEL);
    end
  end

  // Sticky overflow; a rejected write beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (wr_valid && !wr_ready) overflow <= 1'b1;
    else if (err_clr) overflow <= 1'b0;
  end

  sync_prefetch_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (PF_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (ram_q),
    .in_valid  (inflight),
    .in_ready  (q_in_ready_unused),
    .out_data  (rd_data),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .q_cnt     (q_cnt)
  );

endmodule

// File: doc/sync_prefetch_fifo.md
Name: sync_prefetch_fifo

Overview:
- Single-clock first-word-fall-through FIFO for the Ethernet/HSST datapath: an inferred synchronous-read RAM followed by a parametrised prefetch register queue.
- Valid/ready on both sides, occupancy level, programmable almost flags, flush, and sticky overflow detection.
- Successor to the dual-port prefetch FIFO; used where producer and consumer share one clock.

Parameters:
- DATA_W, 32, data width in bits (1..1152).
- ADDR_W, 9, RAM address width; RAM depth = 2^ADDR_W (4..20).
- PF_DEPTH, 2, prefetch queue slots after the RAM (2..4).
- AF_LEVEL, 2^ADDR_W-4, almost_full asserted when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL.
- Derived: CAP = 2^ADDR_W + PF_DEPTH (total capacity); LVL_W = clog2(CAP+1).

Ports:
- clk, in, 1, single clock for the whole block.
- rst, in, 1, synchronous reset, active high.
- flush, in, 1, synchronous clear of stored data; sticky error flag is kept.
- wr_data, in, DATA_W, write data.
- wr_valid, in, 1, write request.
- wr_ready, out, 1, space available; transfer occurs when wr_valid & wr_ready.
- rd_data, out, DATA_W, head-of-queue data, valid while rd_valid is high.
- rd_valid, out, 1, head of queue valid.
- rd_ready, in, 1, consumer accepts; pop occurs when rd_valid & rd_ready.
- level, out, LVL_W, words held: RAM + in-flight read + prefetch queue.
- almost_full, out, 1, level >= AF_LEVEL.
- almost_empty, out, 1, level <= AE_LEVEL.
- overflow, out, 1, sticky; set when wr_valid & ~wr_ready.
- err_clr, in, 1, clears overflow.

Behaviour:
- Reset values:
  - wr_ready=1, rd_valid=0, rd_data=0, level=0, almost_full=0, almost_empty=1, overflow=0.
  - Pointers, RAM count, in-flight flag and queue are cleared. RAM contents are not cleared.
- flush: same effect as rst on all state except overflow. flush has priority over a same-cycle write or pop; the word offered in that cycle is dropped.
- wr_ready = ram_cnt < 2^ADDR_W.
  - Registered-state function only; no combinational path from rd_ready.
  - A pop while full does not raise wr_ready in the same cycle.
- RAM read issue (ram_rd):
  - Condition: ram_cnt > 0 and (q_cnt + inflight - pop) < PF_DEPTH.
  - Data is registered at the issuing edge; inflight is set for one cycle.
  - The queue captures at the next edge.
- Write-to-read latency on an empty FIFO: write accepted at edge E0, ram_rd sampled at E1, rd_valid=1 after E2.
- Sustained throughput: one write and one pop per cycle with no bubbles once the queue is primed.
- Prefetch queue: PF_DEPTH-entry FWFT register FIFO.
  - rd_data/rd_valid always reflect the head entry.
  - Simultaneous capture and pop is allowed at full queue occupancy.
- Level accounting:
  - level_next = level + push - pop, where push = wr_valid & wr_ready.
  - Simultaneous push and pop leaves level unchanged.
  - level never exceeds CAP and never underflows.
  - almost_full and almost_empty are registered from level_next.
- ram_cnt accounting: ram_cnt_next = ram_cnt + push - ram_rd. Pointers wrap modulo 2^ADDR_W.
- Write into an empty RAM while ram_rd is not issuable: the data stays in RAM and is read later. There is no bypass path.
- overflow:
  - Set when wr_valid & ~wr_ready; the offered write is discarded and no state changes.
  - Cleared by rst or err_clr. If set and clear conditions coincide, set wins.
- A pop with rd_valid=0 is ignored (rd_ready is don't-care while rd_valid is low).
- Reset or flush mid-stream: all in-flight data is lost. The first write after release follows the E0..E2 latency.

Decomposition:
- Package sync_fifo_pkg:
  - clog2 function.
  - Localparam helpers for CAP and LVL_W.
  - Level comparison helpers.
- One sub-module, sync_prefetch_queue: the PF_DEPTH-slot FWFT register queue with valid/ready on both sides and a q_cnt output.
- RAM inference and read/write control stay in the top module.

Test Plan (DATA_W=8, ADDR_W=4, PF_DEPTH=2, CAP=18, AF_LEVEL=12, AE_LEVEL=2):
- Single write of 0xA5 into an empty FIFO with rd_ready=0 -> rd_valid=1 and rd_data=0xA5 two cycles after the write edge; level=1.
- 18 back-to-back writes 0x00..0x11 with rd_ready=0 -> wr_ready drops after the 16th RAM word once the queue holds 2 and RAM is full; level=18; almost_full=1 from level 12; 19th write sets overflow with data unchanged.
- From full, rd_ready=1 continuously -> 18 pops in 18 consecutive cycles, values 0x00..0x11 in order; almost_empty=1 at level<=2; then rd_valid=0.
- Continuous write and read with both valid/ready held high for 100 cycles -> no bubbles after priming; level steady; pointer wrap past 15 without data corruption.
- Random wr_valid/rd_ready at 50% each for 2000 cycles -> output order matches a scoreboard model; level matches the model every cycle; overflow never set.
- flush at level=7 with overflow=1 -> next cycle level=0, rd_valid=0, overflow stays 1; err_clr then clears it; rst clears everything.
